// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and constants.
// Used by the fetch front end and its interface.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic {
    S_FETCH,
    S_DROP
  } fetch_state_t;

  function automatic logic word_aligned(
    input logic [1:0] lsb
  );
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-side buses: imem req/ack and the IF->decode valid/ready.
// master is the fetch unit, slave is memory plus decode.
interface fetch_pc_unit_if
  import riscv_pkg::*;
#(
  parameter int W = XLEN
);

  logic            imem_req;
  logic [W-1:0]    imem_addr;
  logic            imem_ack;
  logic [ILEN-1:0] imem_rdata;

  logic            if_valid;
  logic            if_ready;
  logic [W-1:0]    if_pc;
  logic [ILEN-1:0] if_instr;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output if_valid,
    output if_pc,
    output if_instr,
    input  if_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  if_valid,
    input  if_pc,
    input  if_instr,
    output if_ready
  );

endinterface

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Redirect decode, target mux, misalign check and pc+4.
// Purely combinational.
module next_pc_sel
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jump_valid,
  input  logic [XLEN-1:0] jump_target,
  output logic            redirect,
  output logic            misalign,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc_inc
);

  logic take;

  always_comb begin
    take     = jump_valid | (br_valid & br_taken);
    target   = jump_valid ? jump_target : br_target;
    misalign = take & !word_aligned(target[1:0]);
    redirect = take & !misalign;
    pc_inc   = pc + XLEN'(4);
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// RV32I fetch front end: PC, imem handshake, IF output register.
// Redirects flush younger stages; unacked fetches are drained in S_DROP.
module fetch_pc_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN         = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   br_valid,
  input  logic                   br_taken,
  input  logic [XLEN-1:0]        br_target,
  input  logic                   jump_valid,
  input  logic [XLEN-1:0]        jump_target,
  fetch_pc_unit_if.master        bus,
  output logic                   flush,
  output logic                   misalign_exc,
  output logic [XLEN-1:0]        exc_addr
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] held_addr;

  logic            redirect;
  logic            misalign;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_inc;

  logic            out_free;
  logic            req;
  logic            fire;
  logic            pend;

  next_pc_sel #(
    .XLEN(XLEN)
  ) u_sel (
    .pc          (pc),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .redirect    (redirect),
    .misalign    (misalign),
    .target      (target),
    .pc_inc      (pc_inc)
  );

  always_comb begin
    out_free = !bus.if_valid | bus.if_ready;
    req      = 1'b0;
    unique case (state)
      S_FETCH: req = out_free;
      S_DROP:  req = 1'b1;
      default: req = 1'b0;
    endcase
  end

  // Reset gates the request so nothing issues while rst_n is low.
  assign bus.imem_req  = rst_n & req;
  assign bus.imem_addr = (state == S_DROP) ? held_addr : pc;
  assign fire          = bus.imem_req & bus.imem_ack;
  assign pend          = bus.imem_req & !bus.imem_ack;
  assign flush         = rst_n & redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      pc           <= RESET_VECTOR;
      held_addr    <= '0;
      bus.if_valid <= 1'b0;
      bus.if_pc    <= '0;
      bus.if_instr <= '0;
      misalign_exc <= 1'b0;
      exc_addr     <= '0;
    end else begin
      misalign_exc <= misalign;
      if (misalign) begin
        exc_addr <= target;
      end
      if (bus.if_valid & bus.if_ready) begin
        bus.if_valid <= 1'b0;
      end
      unique case (state)
        S_FETCH: begin
          unique case (1'b1)
            redirect & pend: begin
              pc           <= target;
              held_addr    <= pc;
              bus.if_valid <= 1'b0;
              state        <= S_DROP;
            end
            redirect & !pend: begin
              pc           <= target;
              bus.if_valid <= 1'b0;
            end
            !redirect & fire: begin
              bus.if_valid <= 1'b1;
              bus.if_pc    <= pc;
              bus.if_instr <= bus.imem_rdata;
              pc           <= pc_inc;
            end
            default: ;
          endcase
        end
        S_DROP: begin
          if (redirect) begin
            pc           <= target;
            bus.if_valid <= 1'b0;
          end
          if (bus.imem_ack) begin
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
